// File: rtl/dct_quant_zigzag.sv
// 8x8 coefficient capture, zig-zag reorder and JPEG luminance quantization, ping-pong buffered.
// Optional QZ_BYPASS_EN adds qz_bypass, which forces a unity divisor (round + saturate only).
module dct_quant_zigzag #(
  parameter int FRAC    = 20,
  parameter int RECIP_W = 16,
  parameter int OUT_W   = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             coef_valid,
  input  logic [31:0]      coef_in,
  output logic             in_ready,
  output logic             q_valid,
  input  logic             q_ready,
  output logic [OUT_W-1:0] q_out,
  output logic [5:0]       q_index,
  output logic             q_last,
  output logic             overflow,
`ifdef QZ_BYPASS_EN
  input  logic             qz_bypass,
`endif
  output logic             rd_state
);
  // Handshake: a q_* beat transfers on a rising edge where q_valid && q_ready; while
  // q_valid && !q_ready every pipeline stage and the q_* outputs hold their values.

  localparam int PW = 32 + RECIP_W;
  localparam int SH = FRAC + RECIP_W;
  localparam logic signed [PW:0] RND  = {{(PW-SH+1){1'b0}}, 1'b1, {(SH-1){1'b0}}};
  localparam logic signed [PW:0] QMAX = {{(PW-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PW:0] QMIN = -QMAX;

  // Raster address of each zig-zag position.
  localparam int ZZ [64] = '{
     0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
    12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
    35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
    58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63};

  // round(2^16 / Q) for the luminance table, raster order.
  localparam int RECIP [64] = '{
    4096, 5958, 6554, 4096, 2731, 1638, 1285, 1074,
    5461, 5461, 4681, 3449, 2521, 1130, 1092, 1192,
    4681, 5041, 4096, 2731, 1638, 1150,  950, 1170,
    4681, 3855, 2979, 2260, 1285,  753,  819, 1057,
    3641, 2979, 1771, 1170,  964,  601,  636,  851,
    2731, 1872, 1192, 1024,  809,  630,  580,  712,
    1337, 1024,  840,  753,  636,  542,  546,  649,
     910,  712,  690,  669,  585,  655,  636,  662};

  typedef enum logic {IDLE = 1'b0, RUN = 1'b1} rd_state_t;

  rd_state_t          state, state_next;
  logic [31:0]        mem [2][64];
  logic [1:0]         full;
  logic               wr_bank, rd_bank;
  logic [5:0]         wr_cnt;
  logic [6:0]         rd_cnt;
  logic               wr_ok, rd_done, en, issue;
  logic [5:0]         rd_addr;
  logic               v1, v2;
  logic [31:0]        s1_coef;
  logic [RECIP_W:0]   s1_recip;
  logic [5:0]         s1_idx, s2_idx;
  logic [PW-1:0]      s2_p;
  logic signed [PW:0] rnd_sum, r_full;
  logic [OUT_W-1:0]   sat;

  assign wr_ok    = coef_valid && !full[wr_bank];
  assign in_ready = !full[wr_bank];
  assign rd_done  = q_valid && q_ready && q_last;
  assign en       = !(q_valid && !q_ready);
  assign rd_addr  = 6'(ZZ[rd_cnt[5:0]]);
  assign rd_state = (state == RUN);

  always_ff @(posedge clk) begin
    if (wr_ok) mem[wr_bank][wr_cnt] <= coef_in;
  end

  // Set and clear never target the same bank: a write needs it empty, a drain needs it full.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full     <= 2'b00;
      wr_bank  <= 1'b0;
      wr_cnt   <= 6'd0;
      overflow <= 1'b0;
    end else begin
      if (wr_ok) begin
        wr_cnt <= wr_cnt + 6'd1;
        if (wr_cnt == 6'd63) begin
          full[wr_bank] <= 1'b1;
          wr_bank       <= ~wr_bank;
        end
      end
      if (coef_valid && full[wr_bank]) overflow <= 1'b1;
      if (rd_done) full[rd_bank] <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      rd_bank <= 1'b0;
      rd_cnt  <= 7'd0;
    end else begin
      state <= state_next;
      if (rd_done) begin
        rd_bank <= ~rd_bank;
        rd_cnt  <= 7'd0;
      end else if (issue) begin
        rd_cnt <= rd_cnt + 7'd1;
      end
    end
  end

  // The IDLE->RUN cycle already issues position 0; rd_cnt[6] marks all 64 issued.
  always_comb begin
    state_next = state;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        if (full[rd_bank]) begin
          issue      = en;
          state_next = RUN;
        end
      end
      RUN: begin
        issue = en && !rd_cnt[6];
        if (rd_done) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    rnd_sum = {s2_p[PW-1], s2_p} + RND;
    r_full  = rnd_sum >>> SH;
    if (r_full > QMAX)      sat = QMAX[OUT_W-1:0];
    else if (r_full < QMIN) sat = QMIN[OUT_W-1:0];
    else                    sat = r_full[OUT_W-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      v1       <= 1'b0;
      s1_coef  <= 32'd0;
      s1_recip <= '0;
      s1_idx   <= 6'd0;
      v2       <= 1'b0;
      s2_p     <= '0;
      s2_idx   <= 6'd0;
      q_valid  <= 1'b0;
      q_out    <= '0;
      q_index  <= 6'd0;
      q_last   <= 1'b0;
    end else if (en) begin
      v1      <= issue;
      s1_coef <= mem[rd_bank][rd_addr];
      s1_idx  <= rd_cnt[5:0];
`ifdef QZ_BYPASS_EN
      s1_recip <= qz_bypass ? {1'b1, {RECIP_W{1'b0}}} : (RECIP_W+1)'(RECIP[rd_addr]);
`else
      s1_recip <= (RECIP_W+1)'(RECIP[rd_addr]);
`endif
      v2      <= v1;
      // Unsigned multiply of sign/zero-extended operands gives the exact signed low bits.
      s2_p    <= {{RECIP_W{s1_coef[31]}}, s1_coef} * {{(PW-RECIP_W-1){1'b0}}, s1_recip};
      s2_idx  <= s1_idx;
      q_valid <= v2;
      q_out   <= sat;
      q_index <= s2_idx;
      q_last  <= (s2_idx == 6'd63);
    end
  end

endmodule
